alu_op_sched: RTL

- Two-requester scheduler for the 16-bit ALU datapath (NOT/AND/OR/XOR/ADD/SUB/SHL units).
- Arbitrates ALU commands round-robin, latches operands, drives the ALU operand/opcode bus and waits a fixed ALU latency.
- Captures the ALU result and returns it to the winning requester with its ID over a valid/ready response channel.
- Sits between requesting control logic and the ALU top; one command in flight at a time.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_op_sched_if.sv | 48 ++++
 rtl/rr_arb2.sv | 27 ++
 rtl/alu_op_sched.sv | 130 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU operation scheduler: operand width, opcode map and FSM encoding.
package alu_pkg;

  localparam int ALU_W = 16;

  localparam logic [2:0] OP_NOT     = 3'b000;
  localparam logic [2:0] OP_AND     = 3'b001;
  localparam logic [2:0] OP_OR      = 3'b010;
  localparam logic [2:0] OP_XOR     = 3'b011;
  localparam logic [2:0] OP_ADD     = 3'b100;
  localparam logic [2:0] OP_SUB     = 3'b101;
  localparam logic [2:0] OP_SHL     = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_op_sched_if.sv
// Request, ALU and response bundle of the scheduler; rsp_flags exists only with ALU_STATUS_FLAGS_EN.
interface alu_op_sched_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [5:0]         req_op;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;

  logic               alu_start;
  logic [2:0]         alu_op;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [WIDTH-1:0]   alu_result;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_err;
`ifdef ALU_STATUS_FLAGS_EN
  logic [1:0]         rsp_flags;
`endif

  // Scheduler side
  modport slave (
`ifdef ALU_STATUS_FLAGS_EN
    output rsp_flags,
`endif
    input  req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
    output req_ready, alu_start, alu_op, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_data, rsp_err
  );

  // Requesters, ALU and response consumer side
  modport master (
`ifdef ALU_STATUS_FLAGS_EN
    input  rsp_flags,
`endif
    output req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
    input  req_ready, alu_start, alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: on a tie the requester not granted last wins; history moves only on advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant_reg;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last_grant_reg ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
    end else if (advance) begin
      last_grant_reg <= grant[1];
    end
  end

endmodule

// File: rtl/alu_op_sched.sv
// Two-requester ALU command scheduler: arbitrate, issue, wait LATENCY cycles, return the result.
// Optional build macro ALU_STATUS_FLAGS_EN adds rsp_flags = {neg, zero} captured with the result.
module alu_op_sched
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_W,
  parameter int LATENCY = 2
)(
  input  logic          clk,
  input  logic          rst_n,
  alu_op_sched_if.slave bus
);

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

  state_t           state_reg, state_next;
  logic [1:0]       grant;
  logic             advance;
  logic             sel;
  logic             sel_illegal;
  logic [3:0]       cnt_reg;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] a_reg, b_reg, data_reg;
  logic             id_reg, err_reg;

  logic [2:0]       op_arr [2];
  logic [WIDTH-1:0] a_arr  [2];
  logic [WIDTH-1:0] b_arr  [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slice
      assign op_arr[gi] = bus.req_op[3*gi +: 3];
      assign a_arr[gi]  = bus.req_a[WIDTH*gi +: WIDTH];
      assign b_arr[gi]  = bus.req_b[WIDTH*gi +: WIDTH];
    end
  endgenerate

  // Any valid requester yields a grant, so a nonzero grant in IDLE is the handshake.
  assign advance     = (state_reg == ST_IDLE) && (grant != 2'b00);
  assign sel         = grant[1];
  assign sel_illegal = (op_arr[sel] == OP_ILLEGAL);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (bus.req_valid),
    .advance (advance),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (advance) state_next = sel_illegal ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (cnt_reg == 4'd1) state_next = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign bus.req_ready = (state_reg == ST_IDLE) ? grant : 2'b00;
  assign bus.alu_start = (state_reg == ST_ISSUE);
  assign bus.rsp_valid = (state_reg == ST_RESP);
  assign bus.alu_op    = op_reg;
  assign bus.alu_a     = a_reg;
  assign bus.alu_b     = b_reg;
  assign bus.rsp_id    = id_reg;
  assign bus.rsp_data  = data_reg;
  assign bus.rsp_err   = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      op_reg   <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      id_reg   <= 1'b0;
      err_reg  <= 1'b0;
      data_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (advance) begin
            op_reg   <= op_arr[sel];
            a_reg    <= a_arr[sel];
            b_reg    <= b_arr[sel];
            id_reg   <= sel;
            err_reg  <= sel_illegal;
            data_reg <= '0;
          end
        end
        ST_ISSUE: cnt_reg <= LAT_LOAD;
        ST_WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            data_reg <= bus.alu_result;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_STATUS_FLAGS_EN
  logic [1:0] flags_reg;

  assign bus.rsp_flags = flags_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_reg <= 2'b00;
    end else if (advance) begin
      flags_reg <= 2'b00;
    end else if (state_reg == ST_WAIT && cnt_reg == 4'd1) begin
      flags_reg <= {bus.alu_result[WIDTH-1], bus.alu_result == '0};
    end
  end
`endif

endmodule
